// File: rtl/backprop_sequencer_pkg.sv
// Shared types and default sizes for the backprop sequencer and its output slot.
package backprop_sequencer_pkg;

  localparam int unsigned DATA_SIZE_DEF      = 16;
  localparam int unsigned SIZE_DEF           = 3;
  localparam int unsigned MAX_LAYER_SIZE_DEF = 4;
  localparam int unsigned CNT_W              = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PROP = 3'd2,
    ST_GRAD = 3'd3,
    ST_DONE = 3'd4
  } bp_state_e;

  // A pass needs at least one layer and must fit in the stack.
  function automatic logic layers_ok(input logic [CNT_W-1:0] n, input logic [CNT_W-1:0] max_n);
    return (n != '0) && (n <= max_n);
  endfunction

endpackage

// File: rtl/backprop_sequencer_grad_out_slot.sv
// One-entry gradient output register: loads on capture, empties on a valid/ready handshake.
module grad_out_slot
  import backprop_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_SIZE_DEF * SIZE_DEF,
  parameter int unsigned TAG_W  = CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TAG_W-1:0]  layer_i,
  input  logic [TAG_W-1:0]  row_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [TAG_W-1:0]  layer_o,
  output logic [TAG_W-1:0]  row_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAG_W-1:0]  layer_q, layer_d;
  logic [TAG_W-1:0]  row_q, row_d;

  // A capture in the same cycle as a handshake refills the slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    layer_d = layer_q;
    row_d   = row_q;
    if (capture_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      layer_d = layer_i;
      row_d   = row_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      layer_q <= '0;
      row_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      layer_q <= layer_d;
      row_q   <= row_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign layer_o = layer_q;
  assign row_o   = row_q;

endmodule

// File: rtl/backprop_sequencer.sv
// Sequences one backprop pass: load forward rows, propagate dy, then stream gradients
// out in descending-layer / ascending-row order through a one-entry output slot.
module backprop_sequencer
  import backprop_sequencer_pkg::*;
#(
  parameter int unsigned data_size      = DATA_SIZE_DEF,
  parameter int unsigned size           = SIZE_DEF,
  parameter int unsigned max_layer_size = MAX_LAYER_SIZE_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_layers,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      update_storage,
  output logic [CNT_W-1:0]          current_layer,
  output logic                      update_dy_dy_old,
  output logic                      cal_dc_dw,
  output logic [CNT_W-1:0]          dc_dw_layer,
  output logic [CNT_W-1:0]          dc_dw_row,
  output logic                      stack_reset,
  input  logic [data_size*size-1:0] dc_dw_stream,
  output logic                      grad_valid,
  input  logic                      grad_ready,
  output logic [data_size*size-1:0] grad_data,
  output logic [CNT_W-1:0]          grad_layer,
  output logic [CNT_W-1:0]          grad_row,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_error
);

  localparam int unsigned      STREAM_W   = data_size * size;
  localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(size - 1);
  localparam logic [CNT_W-1:0] MAX_LAYERS = CNT_W'(max_layer_size);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  bp_state_e        state_q, state_d;
  logic [CNT_W-1:0] layer_q, layer_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] num_layers_q, num_layers_d;
  logic [CNT_W-1:0] cur_layer_q, cur_layer_d;
  logic [CNT_W-1:0] dc_layer_q, dc_layer_d;
  logic [CNT_W-1:0] dc_row_q, dc_row_d;
  logic             all_issued_q, all_issued_d;
  logic             inflight_q, inflight_d;
  logic             cfg_error_q, cfg_error_d;
  logic             stack_reset_q, stack_reset_d;
  logic             slot_free_c;
  logic             issue_c;

  // The slot can accept a result next cycle if it is empty now or emptying now.
  assign slot_free_c = !grad_valid || grad_ready;
  assign issue_c     = (state_q == ST_GRAD) && !all_issued_q && !inflight_q && slot_free_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      layer_q       <= '0;
      row_q         <= '0;
      num_layers_q  <= '0;
      cur_layer_q   <= '0;
      dc_layer_q    <= '0;
      dc_row_q      <= '0;
      all_issued_q  <= 1'b0;
      inflight_q    <= 1'b0;
      cfg_error_q   <= 1'b0;
      stack_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      layer_q       <= layer_d;
      row_q         <= row_d;
      num_layers_q  <= num_layers_d;
      cur_layer_q   <= cur_layer_d;
      dc_layer_q    <= dc_layer_d;
      dc_row_q      <= dc_row_d;
      all_issued_q  <= all_issued_d;
      inflight_q    <= inflight_d;
      cfg_error_q   <= cfg_error_d;
      stack_reset_q <= stack_reset_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    layer_d       = layer_q;
    row_d         = row_q;
    num_layers_d  = num_layers_q;
    cur_layer_d   = cur_layer_q;
    dc_layer_d    = dc_layer_q;
    dc_row_d      = dc_row_q;
    all_issued_d  = all_issued_q;
    inflight_d    = issue_c;
    cfg_error_d   = 1'b0;
    stack_reset_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (clear) begin
          stack_reset_d = 1'b1;
        end else if (start) begin
          if (layers_ok(num_layers, MAX_LAYERS)) begin
            num_layers_d = num_layers;
            layer_d      = '0;
            row_d        = '0;
            cur_layer_d  = '0;
            state_d      = ST_LOAD;
          end else begin
            cfg_error_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          if (row_q == LAST_ROW) begin
            row_d       = '0;
            layer_d     = layer_q + ONE;
            cur_layer_d = layer_q + ONE;
            if (layer_q == num_layers_q - ONE) begin
              state_d = ST_PROP;
            end
          end else begin
            row_d = row_q + ONE;
          end
        end
      end
      ST_PROP: begin
        layer_d      = num_layers_q - ONE;
        row_d        = '0;
        all_issued_d = 1'b0;
        state_d      = ST_GRAD;
      end
      ST_GRAD: begin
        if (issue_c) begin
          dc_layer_d = layer_q;
          dc_row_d   = row_q;
          if (row_q == LAST_ROW) begin
            if (layer_q == '0) begin
              all_issued_d = 1'b1;
            end else begin
              row_d   = '0;
              layer_d = layer_q - ONE;
            end
          end else begin
            row_d = row_q + ONE;
          end
        end
        if (all_issued_q && !inflight_q && slot_free_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready         = (state_q == ST_LOAD);
    update_storage   = (state_q == ST_LOAD) && in_valid;
    update_dy_dy_old = (state_q == ST_PROP);
    cal_dc_dw        = issue_c;
    dc_dw_layer      = dc_layer_q;
    dc_dw_row        = dc_row_q;
    if (issue_c) begin
      dc_dw_layer = layer_q;
      dc_dw_row   = row_q;
    end
    current_layer    = cur_layer_q;
    busy             = (state_q != ST_IDLE);
    done             = (state_q == ST_DONE);
    cfg_error        = cfg_error_q;
    stack_reset      = stack_reset_q;
  end

  // The stack answers an issue one cycle later; the held tag travels with it.
  grad_out_slot #(
    .DATA_W (STREAM_W),
    .TAG_W  (CNT_W)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .capture_i (inflight_q),
    .data_i    (dc_dw_stream),
    .layer_i   (dc_layer_q),
    .row_i     (dc_row_q),
    .ready_i   (grad_ready),
    .valid_o   (grad_valid),
    .data_o    (grad_data),
    .layer_o   (grad_layer),
    .row_o     (grad_row)
  );

endmodule

// File: tb/tb_backprop_sequencer.sv
// Directed bench for backprop_sequencer: config table, full passes, stall and mid-load reset.
module tb_backprop_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned SZ = 3;
  localparam int unsigned SW = DW * SZ;
  localparam logic [SW-1:0] JUNK = 48'hBAD0_BAD1_BAD2;

  typedef struct {
    logic [31:0] nl;
    logic        clr;
    logic        exp_cfg;
    logic        exp_sr;
  } cfg_vec_t;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
  } tag_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [31:0]   num_layers;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic          update_storage;
  logic [31:0]   current_layer;
  logic          update_dy_dy_old;
  logic          cal_dc_dw;
  logic [31:0]   dc_dw_layer;
  logic [31:0]   dc_dw_row;
  logic          stack_reset;
  logic [SW-1:0] dc_dw_stream;
  logic          grad_valid;
  logic          grad_ready;
  logic [SW-1:0] grad_data;
  logic [31:0]   grad_layer;
  logic [31:0]   grad_row;
  logic          busy;
  logic          done;
  logic          cfg_error;

  int checks = 0;
  int failures = 0;
  int n_store = 0, n_dy = 0, n_cal = 0, n_grad = 0, n_done = 0;
  int cyc = 0, last_cal_cyc = 0;
  bit gap_chk = 1'b0, have_last = 1'b0;
  bit pend = 1'b0;
  logic [31:0] pl = '0, pr = '0;
  logic [31:0] exp_dy = '0;
  logic [31:0] exp_store[$];
  tag_t        exp_grad[$];
  cfg_vec_t    cfg_tab[5];

  backprop_sequencer #(.data_size(DW), .size(SZ), .max_layer_size(4)) dut (
    .clk(clk), .reset(reset), .start(start), .num_layers(num_layers), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .update_storage(update_storage),
    .current_layer(current_layer), .update_dy_dy_old(update_dy_dy_old),
    .cal_dc_dw(cal_dc_dw), .dc_dw_layer(dc_dw_layer), .dc_dw_row(dc_dw_row),
    .stack_reset(stack_reset), .dc_dw_stream(dc_dw_stream), .grad_valid(grad_valid),
    .grad_ready(grad_ready), .grad_data(grad_data), .grad_layer(grad_layer),
    .grad_row(grad_row), .busy(busy), .done(done), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] pat(input logic [15:0] l, input logic [15:0] r);
    return {16'h1000 + l, 16'h2000 + r, 16'hC000 ^ {l[7:0], r[7:0]}};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n0 = n_done;
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (n_done != n0) seen = 1'b1;
    end
    chk(name, 64'(seen), 64'(1));
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stack model: answers an issue with a tag-derived word during the following cycle only.
  always @(posedge clk) begin
    #1;
    dc_dw_stream = pend ? pat(16'(pl), 16'(pr)) : JUNK;
  end

  // Event monitor: scores every strobe and handshake at the falling edge.
  always @(negedge clk) begin
    pend = 1'b0;
    if (update_storage) begin
      n_store++;
      chk("store_layer", 64'(current_layer),
          64'((exp_store.size() == 0) ? 32'hFFFF_FFFF : exp_store.pop_front()));
    end
    if (update_dy_dy_old) begin
      n_dy++;
      chk("dy_old_layer", 64'(current_layer), 64'(exp_dy));
    end
    if (cal_dc_dw) begin
      n_cal++;
      chk("cal_slot_free", 64'(grad_valid && !grad_ready), 64'(0));
      if (gap_chk && have_last) chk("cal_gap", 64'(cyc - last_cal_cyc), 64'(2));
      have_last = 1'b1;
      last_cal_cyc = cyc;
      pend = 1'b1;
      pl = dc_dw_layer;
      pr = dc_dw_row;
    end
    if (grad_valid && grad_ready) begin
      tag_t t;
      n_grad++;
      if (exp_grad.size() == 0) begin
        t.l = 32'hFFFF_FFFF;
        t.r = 32'hFFFF_FFFF;
      end else begin
        t = exp_grad.pop_front();
      end
      chk("grad_layer", 64'(grad_layer), 64'(t.l));
      chk("grad_row", 64'(grad_row), 64'(t.r));
      chk("grad_data", 64'(grad_data), 64'(pat(16'(t.l), 16'(t.r))));
    end
    if (done) n_done++;
  end

  initial begin
    logic [SW-1:0] hold_data;
    logic [31:0]   hold_l, hold_r;
    int            c0, d0;
    bit            seen;

    reset = 1'b0; start = 1'b0; num_layers = '0; clear = 1'b0;
    in_valid = 1'b0; grad_ready = 1'b0; dc_dw_stream = JUNK;

    cfg_tab[0] = '{nl: 32'd0,          clr: 1'b0, exp_cfg: 1'b1, exp_sr: 1'b0};
    cfg_tab[1] = '{nl: 32'd5,          clr: 1'b0, exp_cfg: 1'b1, exp_sr: 1'b0};
    cfg_tab[2] = '{nl: 32'hFFFF_FFFF,  clr: 1'b0, exp_cfg: 1'b1, exp_sr: 1'b0};
    cfg_tab[3] = '{nl: 32'd3,          clr: 1'b1, exp_cfg: 1'b0, exp_sr: 1'b1};
    cfg_tab[4] = '{nl: 32'd0,          clr: 1'b1, exp_cfg: 1'b0, exp_sr: 1'b1};

    // Reset state.
    step(); step();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_grad_valid", 64'(grad_valid), 64'(0));
    chk("rst_grad_data", 64'(grad_data), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_cfg_error", 64'(cfg_error), 64'(0));
    chk("rst_stack_reset", 64'(stack_reset), 64'(0));
    chk("rst_current_layer", 64'(current_layer), 64'(0));
    reset = 1'b1;
    step();
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_cal", 64'(cal_dc_dw), 64'(0));

    // Start/clear configuration table.
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; clear = cfg_tab[i].clr; num_layers = cfg_tab[i].nl;
      step();
      start = 1'b0; clear = 1'b0;
      chk("cfg_error_pulse", 64'(cfg_error), 64'(cfg_tab[i].exp_cfg));
      chk("stack_reset_pulse", 64'(stack_reset), 64'(cfg_tab[i].exp_sr));
      chk("cfg_busy", 64'(busy), 64'(0));
      step();
      chk("cfg_error_end", 64'(cfg_error), 64'(0));
      chk("stack_reset_end", 64'(stack_reset), 64'(0));
      chk("cfg_busy_end", 64'(busy), 64'(0));
    end
    chk("cfg_no_store", 64'(n_store), 64'(0));
    chk("cfg_no_cal", 64'(n_cal), 64'(0));
    chk("cfg_no_dy", 64'(n_dy), 64'(0));

    // Full pass, two layers, ready always high.
    exp_store = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
    exp_dy = 32'd2;
    exp_grad = '{'{32'd1, 32'd0}, '{32'd1, 32'd1}, '{32'd1, 32'd2},
                 '{32'd0, 32'd0}, '{32'd0, 32'd1}, '{32'd0, 32'd2}};
    gap_chk = 1'b1; have_last = 1'b0;
    c0 = n_cal; d0 = n_done;
    start = 1'b1; num_layers = 32'd2; in_valid = 1'b1; grad_ready = 1'b1;
    step();
    start = 1'b0;
    chk("load_busy", 64'(busy), 64'(1));
    chk("load_in_ready", 64'(in_ready), 64'(1));
    wait_done(200, "pass1_done_timeout");
    in_valid = 1'b0;
    step(); step();
    chk("pass1_done_once", 64'(n_done - d0), 64'(1));
    chk("pass1_cal_count", 64'(n_cal - c0), 64'(6));
    chk("pass1_store_count", 64'(n_store), 64'(6));
    chk("pass1_dy_count", 64'(n_dy), 64'(1));
    chk("pass1_grad_left", 64'(exp_grad.size()), 64'(0));
    chk("pass1_hold_dc_layer", 64'(dc_dw_layer), 64'(0));
    chk("pass1_hold_dc_row", 64'(dc_dw_row), 64'(2));
    chk("pass1_hold_cur_layer", 64'(current_layer), 64'(2));
    chk("pass1_idle_busy", 64'(busy), 64'(0));
    chk("pass1_in_ready", 64'(in_ready), 64'(0));
    gap_chk = 1'b0;

    // Single-layer pass with the consumer stalled on the first result.
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_before_pass2", 64'(stack_reset), 64'(1));
    exp_store = '{32'd0, 32'd0, 32'd0};
    exp_dy = 32'd1;
    exp_grad = '{'{32'd0, 32'd0}, '{32'd0, 32'd1}, '{32'd0, 32'd2}};
    start = 1'b1; num_layers = 32'd1; in_valid = 1'b1; grad_ready = 1'b0;
    step();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (grad_valid) seen = 1'b1;
    end
    chk("stall_valid_timeout", 64'(seen), 64'(1));
    hold_data = grad_data; hold_l = grad_layer; hold_r = grad_row;
    chk("stall_first_data", 64'(hold_data), 64'(pat(16'd0, 16'd0)));
    c0 = n_cal;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_valid", 64'(grad_valid), 64'(1));
      chk("stall_data", 64'(grad_data), 64'(hold_data));
      chk("stall_layer", 64'(grad_layer), 64'(hold_l));
      chk("stall_row", 64'(grad_row), 64'(hold_r));
    end
    chk("stall_no_cal", 64'(n_cal - c0), 64'(0));
    grad_ready = 1'b1;
    wait_done(100, "pass2_done_timeout");
    in_valid = 1'b0;
    step();
    chk("pass2_grad_left", 64'(exp_grad.size()), 64'(0));
    chk("pass2_hold_cur_layer", 64'(current_layer), 64'(1));
    chk("pass2_hold_dc_row", 64'(dc_dw_row), 64'(2));
    chk("pass2_grad_valid", 64'(grad_valid), 64'(0));

    // Reset asserted in the middle of LOAD.
    exp_store = '{32'd0, 32'd0, 32'd0, 32'd1};
    start = 1'b1; num_layers = 32'd2; in_valid = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2;
    chk("midload_cur_layer", 64'(current_layer), 64'(1));
    reset = 1'b0;
    #1;
    chk("midload_rst_in_ready", 64'(in_ready), 64'(0));
    chk("midload_rst_storage", 64'(update_storage), 64'(0));
    chk("midload_rst_busy", 64'(busy), 64'(0));
    chk("midload_rst_cur_layer", 64'(current_layer), 64'(0));
    chk("midload_rst_grad_data", 64'(grad_data), 64'(0));
    step();
    reset = 1'b1;
    step();
    chk("after_rst_busy", 64'(busy), 64'(0));
    chk("after_rst_in_ready", 64'(in_ready), 64'(0));
    chk("midload_store_left", 64'(exp_store.size()), 64'(0));
    in_valid = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    chk("after_rst_clear", 64'(stack_reset), 64'(1));
    step();
    chk("after_rst_clear_end", 64'(stack_reset), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/backprop_sequencer.md
BACKPROP_SEQUENCER -- requirements
Module: backprop_sequencer

Interface
REQ-001 Parameter data_size, default 16, width of one signed fixed-point word.
REQ-002 Parameter size, default 3, rows per layer batch and words per stream.
REQ-003 Parameter max_layer_size, default 4, maximum number of layers held by the backprop stack.
REQ-004 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  one-cycle request to run one backprop pass; sampled only in IDLE.
REQ-007 Port num_layers  input  32  layer count for the pass; sampled with start.
REQ-008 Port clear  input  1  one-cycle request to clear the stack; sampled only in IDLE.
REQ-009 Port in_valid / in_ready  input / output  1 / 1  row handshake for the forward-pass rows written into the stack.
REQ-010 Port update_storage, current_layer, update_dy_dy_old, cal_dc_dw, dc_dw_layer, dc_dw_row  output  1, 32, 1, 1, 32, 32  stack control.
REQ-011 Port stack_reset  output  1  active-high stack clear.
REQ-012 Port dc_dw_stream  input  data_size*size  stack gradient result.
REQ-013 Port grad_valid / grad_ready  output / input  1 / 1  gradient output handshake.
REQ-014 Port grad_data, grad_layer, grad_row  output  data_size*size, 32, 32  gradient payload and its tag.
REQ-015 Port busy, done, cfg_error  output  1 each  status outputs.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, PROP, GRAD and DONE.
REQ-017 In IDLE, a start with 1 <= num_layers <= max_layer_size SHALL latch num_layers and enter LOAD with layer=0 and row=0.
REQ-018 In IDLE, a start with an out-of-range num_layers SHALL pulse cfg_error for 1 cycle and remain in IDLE.
REQ-019 In IDLE, clear SHALL assert stack_reset for exactly 1 cycle; if start and clear arrive together, clear wins and start is dropped.
REQ-020 In LOAD, in_ready SHALL be 1, and each in_valid&&in_ready cycle SHALL assert update_storage combinationally with current_layer=layer.
REQ-021 In LOAD, the row counter SHALL advance on each accepted row; after row size-1 it SHALL wrap to 0 and layer SHALL increment.
REQ-022 In LOAD, acceptance of the last row of layer num_layers-1 SHALL move the FSM to PROP.
REQ-023 In PROP, update_dy_dy_old SHALL be asserted for exactly 1 cycle with current_layer=num_layers, followed by a move to GRAD with layer=num_layers-1 and row=0.
REQ-024 In GRAD, cal_dc_dw SHALL be issued with dc_dw_layer=layer and dc_dw_row=row only when no request is in flight and the output slot is empty or draining (!grad_valid || grad_ready).
REQ-025 In the cycle after an issue, dc_dw_stream SHALL be captured into grad_data, with grad_layer and grad_row set to the issued tag and grad_valid set to 1.
REQ-026 The maximum gradient throughput SHALL be one result per 2 cycles.
REQ-027 grad_valid and the payload SHALL hold stable until grad_ready; grad_valid SHALL clear on the handshake unless a new capture occurs in the same cycle.
REQ-028 The GRAD order SHALL be row ascending 0..size-1 within a layer and layer descending num_layers-1..0.
REQ-029 After the last issue, the FSM SHALL enter DONE once the final result has been handed off.
REQ-030 DONE SHALL pulse done for 1 cycle and then return to IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE; in_ready SHALL be 0 outside LOAD; start and clear SHALL be ignored outside IDLE.
REQ-032 Each stack control strobe SHALL be high for at most 1 cycle per event; current_layer, dc_dw_layer and dc_dw_row SHALL hold their last value when idle.

Reset
REQ-033 reset low SHALL force, asynchronously, state=IDLE and all counters=0.
REQ-034 reset low SHALL force all outputs to 0, including grad_data, grad_valid, in_ready, strobes, done, cfg_error and stack_reset.
REQ-035 A reset mid-pass SHALL discard the in-flight result; the stack contents are not cleared, and the host SHALL issue clear before the next pass.

Structure
REQ-036 The state enum and the default data_size, size and max_layer_size constants SHALL live in a shared package beside gdo.
REQ-037 The one-entry gradient output slot SHALL be a sub-module named grad_out_slot; the FSM and counters SHALL stay in the top level.

Verification
REQ-038 Scenario: reset low mid-LOAD -> all outputs 0 within the same cycle; after release, state IDLE and busy=0.
REQ-039 Scenario: start with num_layers=0, then with 5 -> cfg_error pulses twice, busy stays 0, no strobes.
REQ-040 Scenario: num_layers=2, 6 rows with in_valid always high -> 6 update_storage pulses with current_layer 0,0,0,1,1,1, then one update_dy_dy_old with current_layer=2.
REQ-041 Scenario: num_layers=2, grad_ready=1 -> 6 results tagged (1,0),(1,1),(1,2),(0,0),(0,1),(0,2), each grad_data equal to dc_dw_stream one cycle after its cal_dc_dw, then done pulses once.
REQ-042 Scenario: grad_ready held 0 for 10 cycles at the first result -> grad_data and tag stable, no further cal_dc_dw, resumes on release.
REQ-043 Scenario: start and clear high together in IDLE -> stack_reset 1 cycle, FSM stays IDLE.
